tlb_ctrl: RTL and testbench
===========================

Name: tlb_ctrl

Overview:
Controller for a fully-associative TLB built from ENTRIES tlb_entry instances.
- Performs the single-cycle lookup across all entries.
- On a miss, sequences a request/acknowledge handshake with the page-table walker and fills a round-robin victim.
- Sequences invalidate-all and invalidate-by-EA (tlbia/tlbie) and clears all entries at reset.
- Sits between the LSU/fetch translation stage and the shared walker; one instance per I-side and per D-side.

Parameters:
ENTRIES, 8, number of tlb_entry instances; power of two, 2..32.
INSTRUCTION, 0, passed to every tlb_entry; 1 means I-side: pp and Ks outputs are forced to 0 and Kp carries UserEx.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset; 0 = in reset
req_valid  in  1  translation request this cycle
req_ea  in  32  effective address; must be held stable while busy=1
hit  out  1  req_valid and an entry matches (combinational)
pa  out  32  {ppn,12'h0} of the hit entry, else 0
pp  out  2  hit entry PP, else 0
Ks  out  1  hit entry Ks, else 0
Kp  out  1  hit entry Kp/UserEx, else 0
cacheable  out  1  hit entry cacheable, else 0
busy  out  1  miss being serviced (state != IDLE)
fault  out  1  one-cycle pulse: walker reported no translation
inval_all  in  1  invalidate every entry (tlbia)
inval_ea_valid  in  1  invalidate entries whose vpn[5:0] == inval_ea[17:12] (tlbie)
inval_ea  in  32  EA for tlbie
walk_req  out  1  request to walker; held until walk_ack
walk_ea  out  32  {latched req_ea[31:12],12'h0}
walk_ack  in  1  walker result valid (one cycle)
walk_fault  in  1  qualifies walk_ack: no valid PTE
walk_pa  in  32  translated PA
walk_pp  in  2  PTE PP
walk_Ks  in  1  SR Ks
walk_Kp  in  1  SR Kp (UserEx on I-side)
walk_cacheable  in  1  ~WIMG.I

Behaviour:
- Lookup: each entry's ea is driven with req_ea. Every data output is the OR of the entry outputs; entries already zero their outputs on non-match. hit = req_valid & |match. Zero latency. At most one entry matches: fills happen only after a miss and never duplicate a vpn.
- States:
  - IDLE: no miss outstanding.
  - WALK: walker request outstanding.
  - DRAIN: invalidated miss; waits for walk_ack and discards the result.
- IDLE -> WALK when req_valid & ~hit & ~inval_all & ~inval_ea_valid. On that edge, latch vpn = req_ea[31:12]; walk_req=1 from the next cycle.
- WALK, walk_ack & ~walk_fault: pulse load to entry[rr] with the walk_* data and new_ea = latched vpn; rr <= rr+1 (wraps ENTRIES-1 -> 0); go to IDLE. The following cycle hits.
- WALK, walk_ack & walk_fault: no fill, rr unchanged; fault=1 for exactly one cycle; go to IDLE.
- WALK, inval_all or inval_ea_valid without walk_ack: go to DRAIN. The PTE may be stale.
- Invalidate arriving in the same cycle as walk_ack: the invalidate wins; no fill, no fault; go to IDLE.
- DRAIN, walk_ack: discard result, no fault, go to IDLE. The requester re-presents and misses again.
- walk_req=1 in WALK and DRAIN; deasserts the cycle after walk_ack.
- Invalidate drive to entries:
  - reset=0 or inval_all: invalidate=2'b01.
  - Else inval_ea_valid: invalidate=2'b10, with ea to the entries muxed to inval_ea for that cycle. hit is forced to 0 that cycle.
  - Else: 2'b00.
  - inval_all has priority over inval_ea_valid.
  - Invalidates are accepted in any state and take effect at the next edge.
- load is never asserted in a cycle in which any invalidate is driven.
- Reset (reset=0, synchronous, also mid-walk):
  - state=IDLE, rr=0, walk_req=0, fault=0, busy=0.
  - All entries are invalidated every reset cycle.
  - The walker must be reset together with this block; no outstanding walk is tracked across reset.
- busy=1 in WALK and DRAIN. In those states hit follows the lookup normally but the requester stalls.

Decomposition:
- Shared package: state encoding (IDLE/WALK/DRAIN), the invalidate codes (INV_NONE=2'b00, INV_ALL=2'b01, INV_MATCH=2'b10), and DTLB/ITLB perms widths.
- One natural sub-module: tlb_or_reduce, a parameterised OR of per-entry output vectors. Entries are instantiated with a generate loop.

Test Plan:
- Reset held 2 cycles, then req_valid, req_ea=32'h1234_5678 -> hit=0, busy=1 next cycle, walk_req=1, walk_ea=32'h1234_5000.
- walk_ack with walk_pa=32'h0ABC_D000, walk_pp=2'b10, walk_cacheable=1 -> next cycle hit=1, pa=32'h0ABC_D000, pp=2'b10, cacheable=1; rr=1.
- Fill 9 distinct pages with ENTRIES=8 -> the 9th overwrites entry 0; page 1 misses, page 2 hits.
- walk_ack with walk_fault=1 -> fault high exactly one cycle, no fill; re-request misses again.
- Mid-walk inval_ea_valid, inval_ea=32'h0003_F000, then walk_ack -> no fill, no fault, busy drops. Previously filled vpn 20'h0003F misses; vpn 20'h00040 still hits.
- Fill, assert inval_all in the same cycle as a second walk_ack -> all entries miss next cycle, no fill. reset=0 mid-WALK -> walk_req=0 next cycle, all entries miss.

Source files
------------

// File: rtl/tlb_ctrl_pkg.sv
// Shared definitions for the TLB controller: FSM encoding, invalidate codes,
// permission widths and the packed records passed between controller and entries.
package tlb_ctrl_pkg;

  // Controller states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WALK  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // Invalidate command driven to every entry
  localparam logic [1:0] INV_NONE  = 2'b00;
  localparam logic [1:0] INV_ALL   = 2'b01;
  localparam logic [1:0] INV_MATCH = 2'b10;

  // Permission widths: D-side carries PP[1:0], Ks, Kp; I-side only UserEx
  localparam int DTLB_PERM_W = 4;
  localparam int ITLB_PERM_W = 1;

  // Translation data captured from the walker into an entry
  typedef struct packed {
    logic [19:0] ppn;
    logic [1:0]  pp;
    logic        ks;
    logic        kp;
    logic        cacheable;
  } pte_t;

  // Per-entry lookup result; all fields are zero when the entry does not match
  typedef struct packed {
    logic        match;
    logic [31:0] pa;
    logic [1:0]  pp;
    logic        ks;
    logic        kp;
    logic        cacheable;
  } entry_out_t;

endpackage

// File: rtl/tlb_entry.sv
// One fully-associative TLB entry: tag compare, fill and invalidate.
// The lookup vpn doubles as the invalidate-by-EA key when invalidate is INV_MATCH.
module tlb_entry
  import tlb_ctrl_pkg::*;
#(
  parameter bit INSTRUCTION = 1'b0
) (
  input  logic        clk,
  input  logic [1:0]  invalidate,
  input  logic [19:0] ea_vpn,
  input  logic        load,
  input  logic [19:0] new_vpn,
  input  pte_t        new_pte,
  output entry_out_t  out
);

  logic        valid;
  logic [19:0] tag;
  pte_t        pte;
  logic        match;

  // Invalidate has priority over fill; the controller never drives both at once
  always_ff @(posedge clk) begin
    if (invalidate == INV_ALL) begin
      valid <= 1'b0;
    end else if (invalidate == INV_MATCH) begin
      if (tag[5:0] == ea_vpn[5:0]) valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      tag   <= new_vpn;
      pte   <= new_pte;
    end
  end

  // Outputs are zeroed on a miss so the controller can OR entries together
  always_comb begin
    match         = valid && (tag == ea_vpn);
    out           = '0;
    out.match     = match;
    out.pa        = match ? {pte.ppn, 12'h000} : 32'h0;
    out.pp        = (match && !INSTRUCTION) ? pte.pp : 2'b00;
    out.ks        = match && !INSTRUCTION && pte.ks;
    out.kp        = match && pte.kp;
    out.cacheable = match && pte.cacheable;
  end

endmodule

// File: rtl/tlb_or_reduce.sv
// Parameterised OR of N per-entry result vectors. Entries zero their outputs
// on a non-match, so with at most one match the OR selects the hit entry.
module tlb_or_reduce #(
  parameter int N = 8,
  parameter int W = 1
) (
  input  logic [N-1:0][W-1:0] vec,
  output logic [W-1:0]        out
);

  // Fold every entry's vector into one result
  always_comb begin
    out = '0;
    for (int i = 0; i < N; i++) begin
      out = out | vec[i];
    end
  end

endmodule

// File: rtl/tlb_ctrl.sv
// TLB controller: single-cycle lookup over ENTRIES entries, miss handling
// through a req/ack walker handshake with round-robin victim fill, and
// tlbia/tlbie sequencing. state and victim are exposed for observation.
module tlb_ctrl
  import tlb_ctrl_pkg::*;
#(
  parameter int   ENTRIES     = 8,
  parameter bit   INSTRUCTION = 1'b0,
  localparam int  RR_W        = $clog2(ENTRIES)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  input  logic [31:0]     req_ea,
  output logic            hit,
  output logic [31:0]     pa,
  output logic [1:0]      pp,
  output logic            Ks,
  output logic            Kp,
  output logic            cacheable,
  output logic            busy,
  output logic            fault,
  input  logic            inval_all,
  input  logic            inval_ea_valid,
  input  logic [31:0]     inval_ea,
  output logic            walk_req,
  output logic [31:0]     walk_ea,
  input  logic            walk_ack,
  input  logic            walk_fault,
  input  logic [31:0]     walk_pa,
  input  logic [1:0]      walk_pp,
  input  logic            walk_Ks,
  input  logic            walk_Kp,
  input  logic            walk_cacheable,
  output logic [1:0]      state,
  output logic [RR_W-1:0] victim
);

  // Handshake: walk_req rises the cycle after a miss is accepted and stays
  // high until the cycle after walk_ack; walk_ack is a one-cycle strobe and
  // walk_ea is stable for the whole time walk_req is high.

  logic [1:0]             inv_code;
  logic                   inval_any;
  logic [19:0]            lookup_vpn;
  logic [19:0]            vpn;
  logic [RR_W-1:0]        rr;
  logic                   load;
  pte_t                   new_pte;
  entry_out_t [ENTRIES-1:0] entry_out;
  entry_out_t             sel;
  logic                   unused_bits;

  assign inval_any = inval_all | inval_ea_valid;

  // Invalidate command: reset and tlbia clear everything, tlbie clears by key
  always_comb begin
    inv_code = INV_NONE;
    if (!reset || inval_all) inv_code = INV_ALL;
    else if (inval_ea_valid) inv_code = INV_MATCH;
  end

  // tlbie borrows the lookup path to carry its key for one cycle
  assign lookup_vpn = (inv_code == INV_MATCH) ? inval_ea[31:12] : req_ea[31:12];

  // A fill only happens on a clean walker result with no invalidate in flight
  assign load = reset && (state == ST_WALK) && walk_ack && !walk_fault && !inval_any;

  assign new_pte = '{ppn: walk_pa[31:12], pp: walk_pp, ks: walk_Ks,
                     kp: walk_Kp, cacheable: walk_cacheable};

  for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
    tlb_entry #(.INSTRUCTION(INSTRUCTION)) u_entry (
      .clk        (clk),
      .invalidate (inv_code),
      .ea_vpn     (lookup_vpn),
      .load       (load && (rr == RR_W'(i))),
      .new_vpn    (vpn),
      .new_pte    (new_pte),
      .out        (entry_out[i])
    );
  end

  tlb_or_reduce #(.N(ENTRIES), .W($bits(entry_out_t))) u_or (
    .vec (entry_out),
    .out (sel)
  );

  assign hit       = req_valid && sel.match && (inv_code != INV_MATCH);
  assign pa        = sel.pa;
  assign pp        = sel.pp;
  assign Ks        = sel.ks;
  assign Kp        = sel.kp;
  assign cacheable = sel.cacheable;

  assign busy     = (state != ST_IDLE);
  assign walk_req = busy;
  assign walk_ea  = {vpn, 12'h000};
  assign victim   = rr;

  // Miss FSM, round-robin victim pointer and the one-cycle fault pulse
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
      rr    <= '0;
      fault <= 1'b0;
      vpn   <= '0;
    end else begin
      fault <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid && !hit && !inval_any) begin
            state <= ST_WALK;
            vpn   <= req_ea[31:12];
          end
        end
        ST_WALK: begin
          if (walk_ack) begin
            state <= ST_IDLE;
            if (!inval_any) begin
              if (walk_fault) fault <= 1'b1;
              else            rr    <= rr + 1'b1;
            end
          end else if (inval_any) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (walk_ack) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Page-offset bits play no part in translation
  assign unused_bits = ^{req_ea[11:0], inval_ea[11:0], walk_pa[11:0]};

endmodule

// File: tb/tb_tlb_ctrl.sv
// Directed bench for tlb_ctrl: miss/fill, round-robin replacement, walker
// faults, invalidates racing a walk, and reset during a walk.
module tb_tlb_ctrl;
  import tlb_ctrl_pkg::*;

  localparam int ENTRIES = 8;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic [31:0] req_ea;
  logic        hit;
  logic [31:0] pa;
  logic [1:0]  pp;
  logic        Ks;
  logic        Kp;
  logic        cacheable;
  logic        busy;
  logic        fault;
  logic        inval_all;
  logic        inval_ea_valid;
  logic [31:0] inval_ea;
  logic        walk_req;
  logic [31:0] walk_ea;
  logic        walk_ack;
  logic        walk_fault;
  logic [31:0] walk_pa;
  logic [1:0]  walk_pp;
  logic        walk_Ks;
  logic        walk_Kp;
  logic        walk_cacheable;
  logic [1:0]  state;
  logic [2:0]  victim;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  tlb_ctrl #(.ENTRIES(ENTRIES), .INSTRUCTION(1'b0)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ea         (req_ea),
    .hit            (hit),
    .pa             (pa),
    .pp             (pp),
    .Ks             (Ks),
    .Kp             (Kp),
    .cacheable      (cacheable),
    .busy           (busy),
    .fault          (fault),
    .inval_all      (inval_all),
    .inval_ea_valid (inval_ea_valid),
    .inval_ea       (inval_ea),
    .walk_req       (walk_req),
    .walk_ea        (walk_ea),
    .walk_ack       (walk_ack),
    .walk_fault     (walk_fault),
    .walk_pa        (walk_pa),
    .walk_pp        (walk_pp),
    .walk_Ks        (walk_Ks),
    .walk_Kp        (walk_Kp),
    .walk_cacheable (walk_cacheable),
    .state          (state),
    .victim         (victim)
  );

  // Clock and global watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Combinational lookup without letting a miss start a walk
  task automatic probe(input logic [31:0] ea, input logic exp_hit,
                       input logic [31:0] exp_pa, input string tag);
    req_valid = 1'b1;
    req_ea    = ea;
    #1;
    chk({tag, "_hit"}, {31'b0, hit}, {31'b0, exp_hit});
    chk({tag, "_pa"}, pa, exp_pa);
    req_valid = 1'b0;
    #1;
  endtask

  // Present a missing EA, expect the walk to be requested the next cycle
  task automatic start_walk(input logic [31:0] ea, input string tag);
    req_valid = 1'b1;
    req_ea    = ea;
    #1;
    chk({tag, "_miss"}, {31'b0, hit}, 32'd0);
    exp_q.push_back({ea[31:12], 12'h000});
    tick();
    chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
    chk({tag, "_walk_req"}, {31'b0, walk_req}, 32'd1);
    if (walk_req && exp_q.size() != 0) chk({tag, "_walk_ea"}, walk_ea, exp_q.pop_front());
  endtask

  task automatic ack(input logic f, input logic [31:0] p, input logic [1:0] ppv,
                     input logic ks, input logic kp, input logic c);
    walk_ack       = 1'b1;
    walk_fault     = f;
    walk_pa        = p;
    walk_pp        = ppv;
    walk_Ks        = ks;
    walk_Kp        = kp;
    walk_cacheable = c;
    tick();
    walk_ack   = 1'b0;
    walk_fault = 1'b0;
  endtask

  // Full miss + fill, then the held request must hit with the walker's PA
  task automatic fill(input logic [31:0] ea, input logic [31:0] p, input string tag);
    start_walk(ea, tag);
    ack(1'b0, p, 2'b01, 1'b1, 1'b0, 1'b1);
    chk({tag, "_fill_hit"}, {31'b0, hit}, 32'd1);
    chk({tag, "_fill_pa"}, pa, p);
    req_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_ea = '0;
    inval_all = 1'b0; inval_ea_valid = 1'b0; inval_ea = '0;
    walk_ack = 1'b0; walk_fault = 1'b0; walk_pa = '0; walk_pp = '0;
    walk_Ks = 1'b0; walk_Kp = 1'b0; walk_cacheable = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_walk_req", {31'b0, walk_req}, 32'd0);
    chk("rst_fault", {31'b0, fault}, 32'd0);
    chk("rst_state", {30'b0, state}, {30'b0, ST_IDLE});
    chk("rst_victim", {29'b0, victim}, 32'd0);
    reset = 1'b1;

    // First miss and fill
    start_walk(32'h1234_5678, "t1");
    chk("t1_state", {30'b0, state}, {30'b0, ST_WALK});
    ack(1'b0, 32'h0ABC_D000, 2'b10, 1'b0, 1'b1, 1'b1);
    chk("t1_hit", {31'b0, hit}, 32'd1);
    chk("t1_pa", pa, 32'h0ABC_D000);
    chk("t1_pp", {30'b0, pp}, 32'd2);
    chk("t1_cacheable", {31'b0, cacheable}, 32'd1);
    chk("t1_ks", {31'b0, Ks}, 32'd0);
    chk("t1_kp", {31'b0, Kp}, 32'd1);
    chk("t1_victim", {29'b0, victim}, 32'd1);
    chk("t1_busy", {31'b0, busy}, 32'd0);
    req_valid = 1'b0;

    // Reset clears entries; then round-robin replacement over 9 pages
    reset = 1'b0; tick(); reset = 1'b1;
    probe(32'h1234_5000, 1'b0, 32'h0, "t2_cleared");
    for (int i = 1; i <= 9; i++) begin
      fill(32'h1000_0000 | (i << 12), 32'h2000_0000 | (i << 12), $sformatf("rr%0d", i));
    end
    chk("t2_victim", {29'b0, victim}, 32'd1);
    probe(32'h1000_1000, 1'b0, 32'h0, "t2_page1");
    probe(32'h1000_2000, 1'b1, 32'h2000_2000, "t2_page2");
    probe(32'h1000_9000, 1'b1, 32'h2000_9000, "t2_page9");

    // Walker fault: one-cycle pulse, no fill
    start_walk(32'h3000_0000, "t3");
    req_valid = 1'b0;
    ack(1'b1, 32'h5555_5000, 2'b11, 1'b1, 1'b1, 1'b1);
    chk("t3_fault", {31'b0, fault}, 32'd1);
    chk("t3_busy", {31'b0, busy}, 32'd0);
    chk("t3_victim", {29'b0, victim}, 32'd1);
    tick();
    chk("t3_fault_drop", {31'b0, fault}, 32'd0);
    probe(32'h3000_0000, 1'b0, 32'h0, "t3_remiss");

    // tlbie during a walk: drain, discard result
    fill(32'h0003_F000, 32'h4003_F000, "t4a");
    fill(32'h0004_0000, 32'h4004_0000, "t4b");
    chk("t4_victim0", {29'b0, victim}, 32'd3);
    start_walk(32'h5000_0000, "t4");
    inval_ea_valid = 1'b1;
    inval_ea       = 32'h0003_F000;
    req_ea         = 32'h0003_F000;
    #1;
    chk("t4_hit_forced", {31'b0, hit}, 32'd0);
    req_valid = 1'b0;
    tick();
    inval_ea_valid = 1'b0;
    chk("t4_drain", {30'b0, state}, {30'b0, ST_DRAIN});
    chk("t4_drain_req", {31'b0, walk_req}, 32'd1);
    ack(1'b0, 32'h4500_0000, 2'b00, 1'b0, 1'b0, 1'b0);
    chk("t4_busy", {31'b0, busy}, 32'd0);
    chk("t4_fault", {31'b0, fault}, 32'd0);
    chk("t4_walk_req", {31'b0, walk_req}, 32'd0);
    chk("t4_victim", {29'b0, victim}, 32'd3);
    probe(32'h0003_F000, 1'b0, 32'h0, "t4_3f");
    probe(32'h0004_0000, 1'b1, 32'h4004_0000, "t4_40");
    probe(32'h5000_0000, 1'b0, 32'h0, "t4_nofill");

    // tlbia in the same cycle as walk_ack
    fill(32'h6000_0000, 32'h4600_0000, "t5a");
    start_walk(32'h7000_0000, "t5");
    req_valid = 1'b0;
    inval_all = 1'b1;
    ack(1'b0, 32'h4700_0000, 2'b01, 1'b0, 1'b0, 1'b1);
    inval_all = 1'b0;
    chk("t5_busy", {31'b0, busy}, 32'd0);
    chk("t5_fault", {31'b0, fault}, 32'd0);
    chk("t5_victim", {29'b0, victim}, 32'd4);
    probe(32'h6000_0000, 1'b0, 32'h0, "t5_prev");
    probe(32'h0004_0000, 1'b0, 32'h0, "t5_40");
    probe(32'h7000_0000, 1'b0, 32'h0, "t5_nofill");

    // Reset in the middle of a walk
    fill(32'h8000_0000, 32'h4800_0000, "t6a");
    start_walk(32'h9000_0000, "t6");
    req_valid = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("t6_walk_req", {31'b0, walk_req}, 32'd0);
    chk("t6_busy", {31'b0, busy}, 32'd0);
    chk("t6_victim", {29'b0, victim}, 32'd0);
    chk("t6_state", {30'b0, state}, {30'b0, ST_IDLE});
    probe(32'h8000_0000, 1'b0, 32'h0, "t6_cleared");

    chk("exp_q_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
